// File: rtl/regfile_pkg.sv
// Shared defaults and element types for the parameterised register file.
package regfile_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_NWRITE = 1;
    localparam int DEF_AW     = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    reg_addr_t;
    typedef logic [DEF_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: storage mux, same-cycle write forwarding and an optional
// output register.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NWRITE   = DEF_NWRITE,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DEPTH-1:0][WIDTH-1:0]    storage,
    input  logic [NWRITE-1:0]              wr_en,
    input  logic [NWRITE-1:0][AW-1:0]      wr_addr,
    input  logic [NWRITE-1:0][WIDTH-1:0]   wr_data,
    input  logic [AW-1:0]                  rd_addr,
    output logic [WIDTH-1:0]               rd_data
);

    logic [NWRITE-1:0] match_s;
    logic [WIDTH-1:0]  rd_next_s;

    // Per-write-port address match, forced low when forwarding is disabled.
    always_comb begin
        match_s = '0;
        for (int p = 0; p < NWRITE; p++) begin
            if (BYPASS != 0) begin
                match_s[p] = wr_en[p] && (wr_addr[p] == rd_addr);
            end else begin
                match_s[p] = 1'b0;
            end
        end
    end

    // Read value: zero register first, then the higher write port, then storage.
    always_comb begin
        rd_next_s = '0;
        if ((ZERO_REG != 0) && (rd_addr == AW'(DEPTH - 1))) begin
            rd_next_s = '0;
        end else if (match_s[NWRITE-1]) begin
            rd_next_s = wr_data[NWRITE-1];
        end else if (match_s[0]) begin
            rd_next_s = wr_data[0];
        end else begin
            rd_next_s = storage[rd_addr];
        end
    end

    if (READ_LAT != 0) begin : g_reg
        logic [WIDTH-1:0] rd_r;

        // Output pipeline stage, cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_r <= '0;
            end else begin
                rd_r <= rd_next_s;
            end
        end

        assign rd_data = rd_r;
    end else begin : g_comb
        logic unused_clk_s;
        assign unused_clk_s = clk ^ reset;
        assign rd_data      = rd_next_s;
    end

endmodule

// File: rtl/param_regfile.sv
// Parameterised multi-port register file: storage, write decode and NREAD
// read ports with optional forwarding and registered output.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NREAD    = DEF_NREAD,
    parameter int NWRITE   = DEF_NWRITE,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NWRITE-1:0]             RegWrite,
    input  logic [NWRITE-1:0][AW-1:0]     WriteRegister,
    input  logic [NWRITE-1:0][WIDTH-1:0]  WriteData,
    input  logic [NREAD-1:0][AW-1:0]      ReadRegister,
    output logic [NREAD-1:0][WIDTH-1:0]   ReadData
);

    logic [DEPTH-1:0][WIDTH-1:0] storage_r;
    logic [NWRITE-1:0]           wr_en_s;
    logic [DEPTH-1:0]            row_we_s;
    logic [DEPTH-1:0][WIDTH-1:0] row_data_s;

    // Effective write enables; the hard-wired zero register swallows writes.
    always_comb begin
        wr_en_s = '0;
        for (int p = 0; p < NWRITE; p++) begin
            if ((ZERO_REG != 0) && (WriteRegister[p] == AW'(DEPTH - 1))) begin
                wr_en_s[p] = 1'b0;
            end else begin
                wr_en_s[p] = RegWrite[p];
            end
        end
    end

    // Per-row decode; the highest-numbered write port wins a conflict.
    always_comb begin
        row_we_s   = '0;
        row_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_s[NWRITE-1] && (WriteRegister[NWRITE-1] == AW'(i))) begin
                row_we_s[i]   = 1'b1;
                row_data_s[i] = WriteData[NWRITE-1];
            end else if (wr_en_s[0] && (WriteRegister[0] == AW'(i))) begin
                row_we_s[i]   = 1'b1;
                row_data_s[i] = WriteData[0];
            end else begin
                row_we_s[i]   = 1'b0;
                row_data_s[i] = '0;
            end
        end
    end

    // Storage array; reset clears every entry and drops concurrent writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            storage_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (row_we_s[i]) begin
                    storage_r[i] <= row_data_s[i];
                end
            end
        end
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        regfile_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS),
            .READ_LAT (READ_LAT)
        ) u_rdport (
            .clk     (clk),
            .reset   (reset),
            .storage (storage_r),
            .wr_en   (wr_en_s),
            .wr_addr (WriteRegister),
            .wr_data (WriteData),
            .rd_addr (ReadRegister[r]),
            .rd_data (ReadData[r])
        );
    end

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench: five register-file configurations driven by shared
// stimulus and compared with an array-based reference model.
module tb_param_regfile;

    localparam logic [63:0] PAT = 64'h0000010204080001;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd;
    logic [1:0][4:0]  ra;
    logic [1:0][63:0] rd_a, rd_b, rd_c, rd_d, rd_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem1 [32];
    logic [63:0] mem2 [32];
    logic [63:0] exp_d [2];
    logic [63:0] exp_e [2];

    always #5 clk = ~clk;

    // a: defaults (bypass, comb read, one write port)
    param_regfile u_dut_a (
        .clk(clk), .reset(reset), .RegWrite(we[0:0]), .WriteRegister(wa[0:0]),
        .WriteData(wd[0:0]), .ReadRegister(ra), .ReadData(rd_a));
    // b: no bypass
    param_regfile #(.BYPASS(0)) u_dut_b (
        .clk(clk), .reset(reset), .RegWrite(we[0:0]), .WriteRegister(wa[0:0]),
        .WriteData(wd[0:0]), .ReadRegister(ra), .ReadData(rd_b));
    // c: two write ports
    param_regfile #(.NWRITE(2)) u_dut_c (
        .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
        .WriteData(wd), .ReadRegister(ra), .ReadData(rd_c));
    // d: registered read with bypass
    param_regfile #(.READ_LAT(1)) u_dut_d (
        .clk(clk), .reset(reset), .RegWrite(we[0:0]), .WriteRegister(wa[0:0]),
        .WriteData(wd[0:0]), .ReadRegister(ra), .ReadData(rd_d));
    // e: registered read without bypass
    param_regfile #(.READ_LAT(1), .BYPASS(0)) u_dut_e (
        .clk(clk), .reset(reset), .RegWrite(we[0:0]), .WriteRegister(wa[0:0]),
        .WriteData(wd[0:0]), .ReadRegister(ra), .ReadData(rd_e));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural read: reg 31 is zero, else the latest write this cycle
    // (port 1 after port 0) when forwarding, else the stored value.
    function automatic logic [63:0] model_read(input bit dual, input bit fwd, input logic [4:0] addr);
        logic [63:0] v;
        if (addr == 5'd31) return 64'd0;
        v = dual ? mem2[addr] : mem1[addr];
        if (fwd) begin
            if (we[0] && wa[0] == addr) v = wd[0];
            if (dual && we[1] && wa[1] == addr) v = wd[1];
        end
        return v;
    endfunction

    task automatic pre_edge();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (!reset) begin
                check_eq($sformatf("a_rd%0d", r), rd_a[r], model_read(1'b0, 1'b1, ra[r]));
                check_eq($sformatf("b_rd%0d", r), rd_b[r], model_read(1'b0, 1'b0, ra[r]));
                check_eq($sformatf("c_rd%0d", r), rd_c[r], model_read(1'b1, 1'b1, ra[r]));
            end
            exp_d[r] = reset ? 64'd0 : model_read(1'b0, 1'b1, ra[r]);
            exp_e[r] = reset ? 64'd0 : model_read(1'b0, 1'b0, ra[r]);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            check_eq($sformatf("d_rd%0d", r), rd_d[r], exp_d[r]);
            check_eq($sformatf("e_rd%0d", r), rd_e[r], exp_e[r]);
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] = 64'd0;
                mem2[i] = 64'd0;
            end
        end else begin
            if (we[0] && wa[0] != 5'd31) begin
                mem1[wa[0]] = wd[0];
                mem2[wa[0]] = wd[0];
            end
            if (we[1] && wa[1] != 5'd31) mem2[wa[1]] = wd[1];
        end
    endtask

    task automatic tick();
        pre_edge();
        post_edge();
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        we    = 2'b00;
        wa    = '0;
        wd    = '0;
        ra    = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 64'd0;
            mem2[i] = 64'd0;
        end
        idle_inputs();
        reset = 1'b1;
        tick();

        // Reset then sweep all addresses on both ports
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            pre_edge();
            check_eq("rst_sweep", rd_a[0], 64'd0);
            post_edge();
        end

        // Pattern write, then zero-register write
        for (int i = 0; i < 31; i++) begin
            we    = 2'b01;
            wa[0] = 5'(i);
            wd[0] = 64'(i) * PAT;
            ra[0] = 5'(i);
            ra[1] = 5'($urandom);
            tick();
        end
        we = 2'b01; wa[0] = 5'd31; wd[0] = 64'hA0; ra[0] = 5'd31; ra[1] = 5'd31;
        pre_edge();
        check_eq("zero_byp", rd_a[0], 64'd0);
        post_edge();
        we = 2'b00;
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i);
            ra[1] = 5'(i);
            pre_edge();
            check_eq("pat_p0", rd_a[0], (i == 31) ? 64'd0 : 64'(i) * PAT);
            check_eq("pat_p1", rd_a[1], (i == 31) ? 64'd0 : 64'(i) * PAT);
            post_edge();
        end

        // Same-cycle forwarding against a freshly reset file
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we = 2'b01; wa[0] = 5'd5; wd[0] = 64'hDEAD; ra[0] = 5'd5; ra[1] = 5'd5;
        pre_edge();
        check_eq("byp_on", rd_a[0], 64'hDEAD);
        check_eq("byp_off", rd_b[0], 64'd0);
        post_edge();
        we = 2'b00;
        tick();

        // Write-write conflict on reg 7
        we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'h11; wd[1] = 64'h22; ra[0] = 5'd7;
        pre_edge();
        check_eq("wwc_byp", rd_c[0], 64'h22);
        post_edge();
        we = 2'b00;
        pre_edge();
        check_eq("wwc", rd_c[0], 64'h22);
        post_edge();

        // Registered read latency on reg 3
        we = 2'b01; wa[0] = 5'd3; wd[0] = 64'h33; ra[0] = 5'd0; ra[1] = 5'd0;
        tick();
        we = 2'b00; ra[0] = 5'd3;
        pre_edge();
        check_eq("rl_early", rd_d[0], 64'd0);
        post_edge();
        check_eq("rl_lat", rd_d[0], 64'h33);

        // Reset mid-operation with a concurrent write to reg 2
        reset = 1'b1; we = 2'b01; wa[0] = 5'd2; wd[0] = 64'h55; ra[0] = 5'd2;
        tick();
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(a);
            pre_edge();
            check_eq("rst_mid", rd_a[0], 64'd0);
            post_edge();
        end

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            we    = 2'($urandom);
            wa[0] = 5'($urandom);
            wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom);
            wd[0] = {$urandom, $urandom};
            wd[1] = {$urandom, $urandom};
            ra[0] = ($urandom_range(0, 1) == 0) ? wa[0] : 5'($urandom);
            ra[1] = ($urandom_range(0, 2) == 0) ? wa[1] : 5'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
